// File: rtl/pipe_field_scroller.sv
// Scrolling pipe field for the 8x8 matrix: injects random-gap pipes on game ticks,
// shifts them toward column 0, detects collision with the bird column and keeps a pass score.
module pipe_field_scroller #(
  parameter int unsigned TICK_DIV     = 1792,
  parameter int unsigned GAP_H        = 3,
  parameter int unsigned PIPE_SPACING = 4,
  parameter int unsigned BIRD_COL     = 2,
  parameter logic [7:0]  LFSR_SEED    = 8'hA5
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  birdCol,
  output logic [63:0] greenArray,
  output logic        lossDetect,
  output logic [7:0]  score,
  output logic        tick,
  output logic [1:0]  state_dbg
);

  localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned SW = (PIPE_SPACING > 1) ? $clog2(PIPE_SPACING) : 1;
  localparam logic [PW-1:0] PRE_MAX = PW'(TICK_DIV - 1);
  localparam logic [SW-1:0] SP_MAX  = SW'(PIPE_SPACING - 1);
  localparam logic [3:0]    GAP_MOD = 4'(9 - GAP_H);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    LOST = 2'd2
  } state_t;

  state_t        state, state_next;
  logic [PW-1:0] pre;
  logic [SW-1:0] spacing;
  logic [7:0]    lfsr;
  logic [7:0]    bird_col_bits;
  logic [3:0]    gap;
  logic [7:0]    inj_col;
  logic          overlap;
  logic          tick_cycle;
  logic          advance;
  logic          clear_field;

  assign state_dbg     = state;
  assign bird_col_bits = greenArray[BIRD_COL*8 +: 8];
  assign gap           = 4'({1'b0, lfsr[2:0]} % GAP_MOD);

  // Pipe column: solid except for a GAP_H-row hole starting at row gap.
  always_comb begin
    inj_col = '1;
    for (int r = 0; r < 8; r++) begin
      if ((r >= int'(gap)) && (r < int'(gap) + int'(GAP_H))) inj_col[r] = 1'b0;
    end
  end

  // State register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state logic; start is a level, ignored while running
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start)   state_next = RUN;
      RUN:     if (overlap) state_next = LOST;
      LOST:    if (start)   state_next = IDLE;
      default:              state_next = IDLE;
    endcase
  end

  // Output/control decode; a collision on a tick cycle suppresses the advance
  always_comb begin
    overlap     = (state == RUN) && (|(birdCol & bird_col_bits));
    tick_cycle  = (state == RUN) && (pre == PRE_MAX);
    advance     = tick_cycle && !overlap;
    clear_field = (state_next == IDLE);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pre        <= '0;
      spacing    <= '0;
      lfsr       <= LFSR_SEED;
      greenArray <= '0;
      score      <= '0;
      tick       <= 1'b0;
      lossDetect <= 1'b0;
    end else begin
      tick       <= advance;
      lossDetect <= (state_next == LOST);
      if (state == RUN) pre <= tick_cycle ? '0 : pre + 1'b1;
      else              pre <= '0;
      // A fresh game starts from an empty field with a pipe due on the first tick.
      if (clear_field) begin
        greenArray <= '0;
        score      <= '0;
        spacing    <= '0;
      end else if (advance) begin
        greenArray <= {(spacing == '0) ? inj_col : 8'h00, greenArray[63:8]};
        spacing    <= (spacing == '0) ? SP_MAX : spacing - 1'b1;
        lfsr       <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
        if ((|greenArray[7:0]) && (score != 8'hFF)) score <= score + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_pipe_field_scroller.sv
// Directed bench for pipe_field_scroller: fast-tick instance for game behaviour,
// default-tick instance for prescaler spacing.
module tb_pipe_field_scroller;

  logic        clock = 1'b0;
  logic        reset, start;
  logic [7:0]  birdCol;
  logic [63:0] greenArray;
  logic        lossDetect, tick;
  logic [7:0]  score;
  logic [1:0]  state_dbg;

  logic        reset2, start2;
  logic [7:0]  bird2;
  logic [63:0] green2;
  logic        loss2, tick2;
  logic [7:0]  score2;
  logic [1:0]  state2;

  int total = 0;
  int bad   = 0;

  always #5 clock = ~clock;

  pipe_field_scroller #(.TICK_DIV(4)) dut (
    .clock(clock), .reset(reset), .start(start), .birdCol(birdCol),
    .greenArray(greenArray), .lossDetect(lossDetect), .score(score),
    .tick(tick), .state_dbg(state_dbg)
  );

  pipe_field_scroller dut2 (
    .clock(clock), .reset(reset2), .start(start2), .birdCol(bird2),
    .greenArray(green2), .lossDetect(loss2), .score(score2),
    .tick(tick2), .state_dbg(state2)
  );

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic wait_tick(input string tag);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (tick) begin
        seen = 1'b1;
        break;
      end
    end
    chk({tag, "_seen"}, 64'(seen), 64'd1);
  endtask

  initial begin
    int ticks_lost;
    int n;
    bit seen2;
    reset = 1'b0; start = 1'b0; birdCol = 8'h00;
    reset2 = 1'b0; start2 = 1'b0; bird2 = 8'h00;
    repeat (2) step();

    // reset state
    chk("rst_green", greenArray, 64'd0);
    chk("rst_score", 64'(score), 64'd0);
    chk("rst_loss", 64'(lossDetect), 64'd0);
    chk("rst_tick", 64'(tick), 64'd0);
    chk("rst_state", 64'(state_dbg), 64'd0);
    chk("rst_lfsr", 64'(dut.lfsr), 64'hA5);
    reset = 1'b1; reset2 = 1'b1;
    step();
    chk("idle_hold", 64'(state_dbg), 64'd0);

    // run 1: first pipe, spacing, scoring
    start = 1'b1; birdCol = 8'h20;
    step();
    chk("run_entry", 64'(state_dbg), 64'd1);
    step();
    chk("start_ignored", 64'(state_dbg), 64'd1);
    start = 1'b0;
    step(); step();
    chk("tick_early", 64'(tick), 64'd0);
    step();
    chk("tick1", 64'(tick), 64'd1);
    chk("t1_col7", 64'(greenArray[63:56]), 64'h1F);
    chk("t1_lfsr", 64'(dut.lfsr), 64'h4A);
    step();
    chk("tick_pulse_len", 64'(tick), 64'd0);
    wait_tick("t2");
    chk("t2_col7", 64'(greenArray[63:56]), 64'h00);
    wait_tick("t3");
    chk("t3_col7", 64'(greenArray[63:56]), 64'h00);
    wait_tick("t4");
    chk("t4_field", greenArray, 64'h0000_001F_0000_0000);
    wait_tick("t5");
    chk("t5_field", greenArray, 64'h8F00_0000_1F00_0000);
    wait_tick("t6");
    chk("t6_col2", 64'(greenArray[23:16]), 64'h1F);
    chk("t6_loss", 64'(lossDetect), 64'd0);
    wait_tick("t7");
    wait_tick("t8");
    chk("t8_score", 64'(score), 64'd0);
    wait_tick("t9");
    chk("t9_score", 64'(score), 64'd1);
    chk("t9_col7", 64'(greenArray[63:56]), 64'hF8);
    wait_tick("t10");
    chk("t10_field", greenArray, 64'h00F8_0000_008F_0000);
    chk("t10_loss", 64'(lossDetect), 64'd0);

    // collision between ticks
    birdCol = 8'h01;
    step();
    chk("lost_state", 64'(state_dbg), 64'd2);
    chk("lost_loss", 64'(lossDetect), 64'd1);
    ticks_lost = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (tick) ticks_lost++;
    end
    chk("lost_no_tick", 64'(ticks_lost), 64'd0);
    chk("lost_field", greenArray, 64'h00F8_0000_008F_0000);
    chk("lost_score", 64'(score), 64'd1);
    chk("lost_lfsr", 64'(dut.lfsr), 64'h3B);

    // LOST -> IDLE -> RUN, lfsr carries on
    start = 1'b1;
    step();
    start = 1'b0; birdCol = 8'h00;
    chk("idle2_state", 64'(state_dbg), 64'd0);
    chk("idle2_green", greenArray, 64'd0);
    chk("idle2_score", 64'(score), 64'd0);
    chk("idle2_loss", 64'(lossDetect), 64'd0);
    chk("idle2_lfsr", 64'(dut.lfsr), 64'h3B);
    step();
    chk("idle2_hold", 64'(state_dbg), 64'd0);
    start = 1'b1;
    step();
    start = 1'b0;
    wait_tick("r2t1");
    chk("r2_lfsr", 64'(dut.lfsr), 64'h77);
    repeat (4) wait_tick("r2tn");
    chk("r2_field_busy", 64'(greenArray != 64'd0), 64'd1);

    // asynchronous reset between clock edges
    @(posedge clock);
    #3;
    reset = 1'b0;
    #1;
    chk("arst_green", greenArray, 64'd0);
    chk("arst_score", 64'(score), 64'd0);
    chk("arst_state", 64'(state_dbg), 64'd0);
    chk("arst_lfsr", 64'(dut.lfsr), 64'hA5);
    step();
    reset = 1'b1;
    step();

    // run 3: collision on the tick cycle itself freezes everything
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (6) wait_tick("r3");
    chk("r3_t6_field", greenArray, 64'h008F_0000_001F_0000);
    chk("r3_t6_lfsr", 64'(dut.lfsr), 64'h53);
    step(); step(); step();
    birdCol = 8'h01;
    chk("r3_pre_loss", 64'(lossDetect), 64'd0);
    step();
    chk("r3_state", 64'(state_dbg), 64'd2);
    chk("r3_loss", 64'(lossDetect), 64'd1);
    chk("r3_field", greenArray, 64'h008F_0000_001F_0000);
    chk("r3_lfsr", 64'(dut.lfsr), 64'h53);
    chk("r3_score", 64'(score), 64'd0);

    // default prescaler: 1792 cycles per tick
    start2 = 1'b1;
    step();
    start2 = 1'b0;
    n = 0; seen2 = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      step();
      n++;
      if (tick2) begin
        seen2 = 1'b1;
        break;
      end
    end
    chk("d_tick1_seen", 64'(seen2), 64'd1);
    chk("d_tick1_gap", 64'(n), 64'd1792);
    chk("d_col7", 64'(green2[63:56]), 64'h1F);
    n = 0; seen2 = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      step();
      n++;
      if (tick2) begin
        seen2 = 1'b1;
        break;
      end
    end
    chk("d_tick2_seen", 64'(seen2), 64'd1);
    chk("d_tick2_gap", 64'(n), 64'd1792);
    chk("d_loss", 64'(loss2), 64'd0);
    chk("d_score", 64'(score2), 64'd0);
    chk("d_state", 64'(state2), 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
